// File: rtl/seq_div_responder_pkg.sv
// Shared types and constants for the sequential-divide responder core.
// The constant table is entry(i) = i*TableMul + TableOff.
package seq_div_responder_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StDiv,
    StAcc,
    StDone
  } state_e;

  localparam int unsigned TableMul = 37;
  localparam int unsigned TableOff = 11;
  localparam int unsigned RetW     = 32;

endpackage

// File: rtl/seq_div_responder_if.sv
// Start/finish/return_val handshake between the board controller (master)
// and the compute core (slave).
interface seq_div_responder_if;
  import seq_div_responder_pkg::*;

  logic            start;
  logic            finish;
  logic [RetW-1:0] return_val;

  modport master (output start, input finish, input return_val);
  modport slave  (input start, output finish, output return_val);

endinterface

// File: rtl/seq_divider.sv
// DIV_W-bit restoring divider: one quotient bit per cycle, MSB first.
// A zero divisor yields an all-ones quotient.
module seq_divider #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [DIV_W-1:0] i_dividend,
  input  logic [DIV_W-1:0] i_divisor,
  output logic [DIV_W-1:0] o_quotient,
  output logic             o_done
);

  localparam int unsigned CntW = $clog2(DIV_W + 1);

  logic [DIV_W-1:0] r_rem;
  logic [DIV_W-1:0] r_quo;
  logic [DIV_W-1:0] r_dvs;
  logic [CntW-1:0]  r_cnt;

  logic [DIV_W:0]   w_trial;
  logic [DIV_W-1:0] w_diff;
  logic             w_qbit;

  // r_quo holds the unconsumed dividend bits and fills with quotient bits from the LSB.
  always_comb begin
    w_trial = {r_rem, r_quo[DIV_W-1]};
    w_qbit  = (w_trial >= {1'b0, r_dvs});
    w_diff  = w_trial[DIV_W-1:0] - r_dvs;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rem <= '0;
      r_quo <= '0;
      r_dvs <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_rem <= '0;
      r_quo <= i_dividend;
      r_dvs <= i_divisor;
      r_cnt <= CntW'(DIV_W);
    end else if (r_cnt != '0) begin
      r_rem <= w_qbit ? w_diff : w_trial[DIV_W-1:0];
      r_quo <= (r_quo << 1) | DIV_W'(w_qbit);
      r_cnt <= r_cnt - CntW'(1);
    end
  end

  assign o_quotient = r_quo;
  // High in the cycle whose closing edge retires the last quotient bit.
  assign o_done     = (r_cnt == CntW'(1));

endmodule

// File: rtl/seq_div_responder.sv
// Stand-in compute core: on start, divides each constant-table entry by (index+1),
// sums the quotients and pulses finish with the sum on return_val.
module seq_div_responder
  import seq_div_responder_pkg::*;
#(
  parameter int unsigned DIV_W    = 8,
  parameter int unsigned NUM_INST = 4,
  parameter int unsigned ADDR_W   = 2
) (
  input logic                clk,
  input logic                reset,
  seq_div_responder_if.slave bus
);

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_INST - 1);

  state_e            r_state;
  state_e            w_state_d;
  logic [ADDR_W-1:0] r_idx;
  logic [RetW-1:0]   r_acc;
  logic [RetW-1:0]   r_return_val;
  logic              r_finish;

  logic              w_div_load;
  logic              w_div_done;
  logic [DIV_W-1:0]  w_dividend;
  logic [DIV_W-1:0]  w_divisor;
  logic [DIV_W-1:0]  w_quotient;

  function automatic logic [DIV_W-1:0] table_entry(input logic [ADDR_W-1:0] i);
    logic [31:0] v;
    v = 32'(i) * TableMul + TableOff;
    return v[DIV_W-1:0];
  endfunction

  function automatic logic [DIV_W-1:0] table_divisor(input logic [ADDR_W-1:0] i);
    logic [31:0] v;
    v = 32'(i) + 32'd1;
    return v[DIV_W-1:0];
  endfunction

  assign w_dividend = table_entry(r_idx);
  assign w_divisor  = table_divisor(r_idx);

  always_comb begin
    w_state_d  = r_state;
    w_div_load = 1'b0;
    unique case (r_state)
      StIdle: if (bus.start) w_state_d = StLoad;
      StLoad: begin
        w_div_load = 1'b1;
        w_state_d  = StDiv;
      end
      StDiv:  if (w_div_done) w_state_d = StAcc;
      StAcc:  w_state_d = (r_idx == LastIdx) ? StDone : StLoad;
      StDone: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_d;
  end

  // finish and return_val both register on the DONE edge so they appear in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx        <= '0;
      r_acc        <= '0;
      r_return_val <= '0;
      r_finish     <= 1'b0;
    end else begin
      r_finish <= (r_state == StDone);
      if (r_state == StIdle && bus.start) begin
        r_idx        <= '0;
        r_acc        <= '0;
        r_return_val <= '0;
      end
      if (r_state == StAcc) begin
        r_acc <= r_acc + RetW'(w_quotient);
        if (r_idx != LastIdx) r_idx <= r_idx + ADDR_W'(1);
      end
      if (r_state == StDone) r_return_val <= r_acc;
    end
  end

  seq_divider #(
    .DIV_W(DIV_W)
  ) u_div (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_div_load),
    .i_dividend (w_dividend),
    .i_divisor  (w_divisor),
    .o_quotient (w_quotient),
    .o_done     (w_div_done)
  );

  assign bus.finish     = r_finish;
  assign bus.return_val = r_return_val;

endmodule

// File: tb/tb_seq_div_responder.sv
// Bench for seq_div_responder: three parameterisations, finish events logged
// with cycle stamps and compared against an arithmetic model of the table sums.
module tb_seq_div_responder;

  logic clk = 1'b0;
  logic reset;
  logic start;
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_div_responder_if if0 ();
  seq_div_responder_if if1 ();
  seq_div_responder_if if2 ();
  assign if0.start = start;
  assign if1.start = start;
  assign if2.start = start;

  seq_div_responder #(.DIV_W(8), .NUM_INST(4), .ADDR_W(2)) dut0 (
    .clk(clk), .reset(reset), .bus(if0.slave));
  seq_div_responder #(.DIV_W(8), .NUM_INST(1), .ADDR_W(1)) dut1 (
    .clk(clk), .reset(reset), .bus(if1.slave));
  seq_div_responder #(.DIV_W(2), .NUM_INST(4), .ADDR_W(3)) dut2 (
    .clk(clk), .reset(reset), .bus(if2.slave));

  typedef struct {
    int unsigned c;
    logic [31:0] v;
  } fin_t;
  fin_t q0[$];
  fin_t q1[$];
  fin_t q2[$];

  always @(negedge clk) begin
    if (if0.finish === 1'b1) q0.push_back('{cyc, if0.return_val});
    if (if1.finish === 1'b1) q1.push_back('{cyc, if1.return_val});
    if (if2.finish === 1'b1) q2.push_back('{cyc, if2.return_val});
  end

  function automatic logic [31:0] ref_sum(input int unsigned w, input int unsigned n);
    longint unsigned m, s, e, d;
    m = 64'd1 << w;
    s = 0;
    for (int unsigned i = 0; i < n; i++) begin
      e = (64'(i) * 37 + 11) % m;
      d = (64'(i) + 1) % m;
      s += (d == 0) ? (m - 1) : (e / d);
    end
    return s[31:0];
  endfunction

  function automatic int unsigned ref_lat(input int unsigned w, input int unsigned n);
    return 1 + n * (w + 2);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(output int unsigned t0);
    start = 1'b1;
    tick();
    t0 = cyc;
    start = 1'b0;
  endtask

  task automatic check_run(input string tag, input fin_t q[$], input int unsigned t0,
                           input int unsigned lat, input logic [31:0] sum);
    check({tag, " finish count"}, 32'(q.size()), 32'd1);
    if (q.size() > 0) begin
      check({tag, " finish cycle"}, q[0].c - t0, lat);
      check({tag, " return_val"}, q[0].v, sum);
    end
  endtask

  initial begin
    int unsigned t0, rk, rmid;
    logic [31:0] s0;
    int unsigned l0;
    s0 = ref_sum(8, 4);
    l0 = ref_lat(8, 4);
    reset = 1'b1;
    start = 1'b0;
    repeat (3) tick();
    check("reset finish", 32'(if0.finish), 32'd0);
    check("reset return_val", if0.return_val, 32'd0);
    reset = 1'b0;
    repeat ($urandom_range(1, 6)) tick();

    // Single start on all three configurations.
    q0.delete(); q1.delete(); q2.delete();
    pulse_start(t0);
    repeat (10) tick();
    check("mid-run return_val", if0.return_val, 32'd0);
    repeat (50) tick();
    check_run("cfg default", q0, t0, l0, s0);
    check_run("cfg n1", q1, t0, ref_lat(8, 1), ref_sum(8, 1));
    check_run("cfg wrap", q2, t0, ref_lat(2, 4), ref_sum(2, 4));
    check("held return_val", if0.return_val, s0);
    check("held finish", 32'(if0.finish), 32'd0);
    check("held n1 return_val", if1.return_val, ref_sum(8, 1));
    check("held wrap return_val", if2.return_val, ref_sum(2, 4));
    repeat ($urandom_range(1, 6)) tick();

    // Extra starts while busy and during DONE must be ignored.
    q0.delete();
    rmid = $urandom_range(6, 39);
    pulse_start(t0);
    for (int unsigned k = 1; k <= 100; k++) begin
      start = (k == 5 || k == rmid || k == l0) ? 1'b1 : 1'b0;
      tick();
    end
    start = 1'b0;
    check_run("ignored starts", q0, t0, l0, s0);
    check("ignored starts held", if0.return_val, s0);
    repeat ($urandom_range(1, 6)) tick();

    // Asynchronous reset during the finish cycle.
    q0.delete();
    pulse_start(t0);
    repeat (l0) tick();
    check("pre-reset finish", 32'(if0.finish), 32'd1);
    reset = 1'b1;
    #1;
    check("async reset finish", 32'(if0.finish), 32'd0);
    check("async reset return_val", if0.return_val, 32'd0);
    repeat (2) tick();
    reset = 1'b0;
    tick();

    // Reset mid-run aborts without a finish; a new run completes normally.
    q0.delete();
    rk = $urandom_range(2, 38);
    pulse_start(t0);
    repeat (rk) tick();
    reset = 1'b1;
    #1;
    check("mid-run reset finish", 32'(if0.finish), 32'd0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (50) tick();
    check("aborted run finishes", 32'(q0.size()), 32'd0);
    pulse_start(t0);
    repeat (50) tick();
    check_run("after abort", q0, t0, l0, s0);
    repeat ($urandom_range(1, 6)) tick();

    // Start held high: back-to-back runs every l0+1 cycles.
    q0.delete();
    start = 1'b1;
    tick();
    t0 = cyc;
    repeat (10) tick();
    check("held-start cleared return_val", if0.return_val, 32'd0);
    repeat (126) tick();
    start = 1'b0;
    repeat (50) tick();
    check("held-start finish count", 32'(q0.size()), 32'd4);
    for (int unsigned j = 0; j < 4; j++) begin
      if (j < q0.size()) begin
        check($sformatf("held-start run%0d cycle", j), q0[j].c - t0, l0 + j * (l0 + 1));
        check($sformatf("held-start run%0d value", j), q0[j].v, s0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
